game_sequencer: RTL and testbench

Top-level game controller for the asteroid dodging game. Sequences the player-position datapath and the asteroid scroller through idle, play, hit and game-over phases. It accepts shaped one-cycle button pulses, rate-limits lane toggles, issues respawn resets and scroll ticks, and tracks remaining lives. It sits between the button shapers and the PlayerPosition and asteroid blocks.

---
 rtl/game_sequencer.sv | 144 ++++++++++++++
 tb/tb_game_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Top-level sequencer for the asteroid dodging game: walks IDLE/PLAYING/HIT/OVER,
// rate-limits lane toggles, paces asteroid scrolling and counts down lives.
module game_sequencer #(
  parameter int COOLDOWN_CYCLES = 4,
  parameter int LIVES           = 3,
  parameter int HIT_HOLD_CYCLES = 8,
  parameter int TICK_DIV        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       StartBtn,
  input  logic       ToggleBtn,
  input  logic       Collision,
  output logic       PlayerToggle,
  output logic       PlayerRst,
  output logic       AsteroidTick,
  output logic [3:0] LivesLeft,
  output logic [1:0] GameState,
  output logic       GameOver
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam int HW = $clog2(HIT_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAYING = 2'b01,
    S_HIT     = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [CW-1:0] cool_cnt, cool_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [3:0]    lives_nxt;
  logic          toggle_nxt, prst_nxt, atick_nxt, over_nxt;

  always_comb begin
    state_nxt  = state;
    lives_nxt  = LivesLeft;
    tick_nxt   = tick_cnt;
    cool_nxt   = cool_cnt;
    hold_nxt   = hold_cnt;
    toggle_nxt = 1'b0;
    atick_nxt  = 1'b0;
    prst_nxt   = PlayerRst;
    over_nxt   = GameOver;

    case (state)
      S_IDLE: begin
        prst_nxt = 1'b0;
        over_nxt = 1'b0;
        if (StartBtn) begin
          state_nxt = S_PLAYING;
          lives_nxt = 4'(LIVES);
          tick_nxt  = '0;
          cool_nxt  = '0;
          hold_nxt  = '0;
          prst_nxt  = 1'b1;
        end
      end

      S_PLAYING: begin
        prst_nxt = 1'b1;
        // A collision pre-empts any toggle or scroll tick due on the same edge.
        if (Collision) begin
          if (LivesLeft > 4'd1) begin
            state_nxt = S_HIT;
            lives_nxt = LivesLeft - 4'd1;
            hold_nxt  = HW'(HIT_HOLD_CYCLES);
          end else begin
            state_nxt = S_OVER;
            lives_nxt = 4'd0;
            over_nxt  = 1'b1;
          end
        end else begin
          tick_nxt  = (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
          atick_nxt = (tick_cnt == TW'(TICK_DIV - 2));
          if (ToggleBtn && (cool_cnt == '0)) begin
            toggle_nxt = 1'b1;
            cool_nxt   = CW'(COOLDOWN_CYCLES);
          end else if (cool_cnt != '0) begin
            cool_nxt = cool_cnt - 1'b1;
          end
        end
      end

      S_HIT: begin
        if (hold_cnt <= HW'(1)) begin
          // Respawn: one low cycle on PlayerRst returns the player to the top lane.
          state_nxt = S_PLAYING;
          hold_nxt  = '0;
          tick_nxt  = '0;
          cool_nxt  = '0;
          prst_nxt  = 1'b0;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end

      S_OVER: begin
        over_nxt  = 1'b1;
        lives_nxt = 4'd0;
        prst_nxt  = 1'b1;
        if (StartBtn) begin
          state_nxt = S_IDLE;
          over_nxt  = 1'b0;
          prst_nxt  = 1'b0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      cool_cnt     <= '0;
      hold_cnt     <= '0;
      LivesLeft    <= 4'd0;
      PlayerToggle <= 1'b0;
      PlayerRst    <= 1'b0;
      AsteroidTick <= 1'b0;
      GameOver     <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick_cnt     <= tick_nxt;
      cool_cnt     <= cool_nxt;
      hold_cnt     <= hold_nxt;
      LivesLeft    <= lives_nxt;
      PlayerToggle <= toggle_nxt;
      PlayerRst    <= prst_nxt;
      AsteroidTick <= atick_nxt;
      GameOver     <= over_nxt;
    end
  end

  assign GameState = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with default parameters (C=4, LIVES=3, HOLD=8, TICK_DIV=16).
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       StartBtn = 1'b0;
  logic       ToggleBtn = 1'b0;
  logic       Collision = 1'b0;
  logic       PlayerToggle, PlayerRst, AsteroidTick, GameOver;
  logic [3:0] LivesLeft;
  logic [1:0] GameState;

  int n_checks = 0;
  int n_fail   = 0;

  game_sequencer #(
    .COOLDOWN_CYCLES(4),
    .LIVES(3),
    .HIT_HOLD_CYCLES(8),
    .TICK_DIV(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .StartBtn(StartBtn),
    .ToggleBtn(ToggleBtn),
    .Collision(Collision),
    .PlayerToggle(PlayerToggle),
    .PlayerRst(PlayerRst),
    .AsteroidTick(AsteroidTick),
    .LivesLeft(LivesLeft),
    .GameState(GameState),
    .GameOver(GameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, t, c;
    logic       tog, prst, tick;
    logic [3:0] lives;
    logic [1:0] st;
    logic       ov;
  } vec_t;

  vec_t vecs[19];

  // Output bundle order: {PlayerToggle, PlayerRst, AsteroidTick, LivesLeft, GameState, GameOver}
  function automatic logic [9:0] outs();
    return {PlayerToggle, PlayerRst, AsteroidTick, LivesLeft, GameState, GameOver};
  endfunction

  function automatic logic [9:0] pack(input vec_t v);
    return {v.tog, v.prst, v.tick, v.lives, v.st, v.ov};
  endfunction

  function automatic vec_t mk(input logic s, input logic t, input logic c,
                              input logic tog, input logic prst, input logic tick,
                              input logic [3:0] lives, input logic [1:0] st, input logic ov);
    vec_t v;
    v.s = s; v.t = t; v.c = c;
    v.tog = tog; v.prst = prst; v.tick = tick;
    v.lives = lives; v.st = st; v.ov = ov;
    return v;
  endfunction

  task automatic chk_bus(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got tog/prst/tick/lives/state/over=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock edge with the given one-cycle inputs; outputs are settled 1ns after the edge.
  task automatic step(input logic s, input logic t, input logic c);
    @(negedge clk);
    StartBtn = s; ToggleBtn = t; Collision = c;
    @(posedge clk);
    #1;
    StartBtn = 1'b0; ToggleBtn = 1'b0; Collision = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, first_tick, bad_cyc;

    // Toggle/cooldown: entry at row 0, toggle N=row1 accepted, N+2 and N+4 dropped, N+5 accepted
    vecs[0]  = mk(1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    vecs[1]  = mk(1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    vecs[2]  = mk(1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    vecs[3]  = mk(1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    vecs[4]  = mk(1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    vecs[5]  = mk(1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    vecs[6]  = mk(1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    vecs[7]  = mk(1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    vecs[8]  = mk(1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd3, 2'b01, 1'b0);
    // Non-fatal hit at row 9; inputs ignored during hold; respawn after 8 edges (row 17)
    vecs[9]  = mk(1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 4'd2, 2'b10, 1'b0);
    vecs[10] = mk(1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 4'd2, 2'b10, 1'b0);
    vecs[11] = mk(1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 4'd2, 2'b10, 1'b0);
    vecs[12] = mk(1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd2, 2'b10, 1'b0);
    vecs[13] = mk(1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 4'd2, 2'b10, 1'b0);
    vecs[14] = mk(1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd2, 2'b10, 1'b0);
    vecs[15] = mk(1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd2, 2'b10, 1'b0);
    vecs[16] = mk(1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd2, 2'b10, 1'b0);
    vecs[17] = mk(1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 4'd2, 2'b01, 1'b0);
    // Cooldown cleared on re-entry, so an immediate toggle is accepted
    vecs[18] = mk(1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 4'd2, 2'b01, 1'b0);

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk_bus("reset_values", outs(), 10'b0_0_0_0000_00_0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk_bus("idle_no_start", outs(), 10'b0_0_0_0000_00_0);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].s, vecs[i].t, vecs[i].c);
      chk_bus($sformatf("vec%0d", i), outs(), pack(vecs[i]));
    end

    // Tick cadence after respawn: rows 17/18 were cycles 1 and 2, run cycles 3..64
    ticks = 0; first_tick = 0; bad_cyc = 0;
    for (int cyc = 3; cyc <= 64; cyc++) begin
      step(1'b0, 1'b0, 1'b0);
      if (AsteroidTick === 1'b1) begin
        ticks++;
        if (first_tick == 0) first_tick = cyc;
      end
      if (AsteroidTick !== ((cyc % 16) == 0)) bad_cyc++;
    end
    chk_int("tick_count_64", ticks, 4);
    chk_int("tick_first_cycle", first_tick, 16);
    chk_int("tick_spacing_errors", bad_cyc, 0);

    // Second hit leaves one life
    step(1'b0, 1'b0, 1'b1);
    chk_bus("hit2_enter", outs(), 10'b0_1_0_0001_10_0);
    repeat (7) step(1'b0, 1'b1, 1'b0);
    chk_bus("hit2_hold_end", outs(), 10'b0_1_0_0001_10_0);
    step(1'b0, 1'b0, 1'b0);
    chk_bus("hit2_respawn", outs(), 10'b0_0_0_0001_01_0);

    // Cycles 2..15 after respawn: no tick yet; the tick due at cycle 16 collides
    ticks = 0;
    for (int cyc = 2; cyc <= 15; cyc++) begin
      step(1'b0, 1'b0, 1'b0);
      if (AsteroidTick === 1'b1) ticks++;
    end
    chk_int("no_early_tick", ticks, 0);
    step(1'b0, 1'b1, 1'b1);
    chk_bus("fatal_simultaneous", outs(), 10'b0_1_0_0000_11_1);

    step(1'b0, 1'b1, 1'b0);
    chk_bus("over_no_toggle", outs(), 10'b0_1_0_0000_11_1);
    step(1'b0, 1'b0, 1'b0);
    chk_bus("over_holds", outs(), 10'b0_1_0_0000_11_1);
    step(1'b1, 1'b0, 1'b0);
    chk_bus("over_to_idle", outs(), 10'b0_0_0_0000_00_0);
    step(1'b0, 1'b0, 1'b0);
    chk_bus("idle_wait", outs(), 10'b0_0_0_0000_00_0);
    step(1'b1, 1'b0, 1'b0);
    chk_bus("restart", outs(), 10'b0_1_0_0011_01_0);

    // Asynchronous reset between edges while in HIT
    step(1'b0, 1'b0, 1'b1);
    chk_bus("hit3_enter", outs(), 10'b0_1_0_0010_10_0);
    #2;
    rst = 1'b0;
    #1;
    chk_bus("async_reset_mid_hit", outs(), 10'b0_0_0_0000_00_0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk_bus("after_reset_idle", outs(), 10'b0_0_0_0000_00_0);
    step(1'b1, 1'b0, 1'b0);
    chk_bus("start_after_reset", outs(), 10'b0_1_0_0011_01_0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
